// File: rtl/fxp_vec_acc.sv
// Streaming saturating accumulator for the softmax denominator.
// Sums LEN fixed-point products and holds the result until taken.
module fxp_vec_acc #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int CNT_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] sum_o,
  output logic              sum_valid_o,
  input  logic              sum_ready_i,
  output logic              sat_o,
  output logic              busy_o
);

  // Input and sum share one Q format, so FRAC_W only has to be sane.
  if (FRAC_W >= DATA_W) begin : g_bad_frac
    $error("FRAC_W must be smaller than DATA_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  state_t             state;
  state_t             state_n;
  logic [DATA_W-1:0]  acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_q;
  logic               sat;
  logic               fire;
  logic               last;
  logic [DATA_W:0]    wide;
  logic               ovf;
  logic [DATA_W-1:0]  add_res;

  assign fire = valid_i && ready_o;
  assign last = (cnt == len_q - 1'b1);

  // Widened add; a sign mismatch in the top two bits means overflow.
  always_comb begin
    wide    = {acc[DATA_W-1], acc} + {data_i[DATA_W-1], data_i};
    ovf     = wide[DATA_W] ^ wide[DATA_W-1];
    add_res = wide[DATA_W-1:0];
    if (ovf) add_res = wide[DATA_W] ? MIN_V : MAX_V;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; start is only seen while idle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start_i) state_n = (len_i == '0) ? DONE : ACC;
      end
      ACC: begin
        if (fire && last) state_n = DONE;
      end
      DONE: begin
        if (sum_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready_o     = (state == ACC);
    sum_valid_o = (state == DONE);
    busy_o      = (state != IDLE);
  end

  // Accumulator, element counter, latched length and sticky saturation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      sat   <= 1'b0;
    end else if (state == IDLE && start_i) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= len_i;
      sat   <= 1'b0;
    end else if (fire) begin
      acc   <= add_res;
      cnt   <= cnt + 1'b1;
      sat   <= sat | ovf;
    end
  end

  assign sum_o = acc;
  assign sat_o = sat;

endmodule

// File: tb/tb_fxp_vec_acc.sv
// Randomized bench for fxp_vec_acc against a plain-integer model.
// Drives and samples on the falling clock edge.
module tb_fxp_vec_acc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [9:0]  len_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] sum_o;
  logic        sum_valid_o;
  logic        sum_ready_i;
  logic        sat_o;
  logic        busy_o;

  int n_chk = 0;
  int n_err = 0;

  fxp_vec_acc dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .sum_o       (sum_o),
    .sum_valid_o (sum_valid_o),
    .sum_ready_i (sum_ready_i),
    .sat_o       (sat_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer running sum clamped after every add.
  task automatic ref_sum(input logic [31:0] v[$],
                         output logic [31:0] s, output logic st);
    longint acc;
    acc = 0;
    st  = 1'b0;
    foreach (v[i]) begin
      acc = acc + longint'($signed(v[i]));
      if (acc > 64'sd2147483647) begin
        acc = 64'sd2147483647;
        st  = 1'b1;
      end else if (acc < -64'sd2147483648) begin
        acc = -64'sd2147483648;
        st  = 1'b1;
      end
    end
    s = acc[31:0];
  endtask

  // gaps: bit k set -> valid_i low on the k-th cycle in ACC.
  task automatic run_vec(input logic [31:0] v[$], input logic [31:0] gaps,
                         input int stall, input bit ign_start,
                         input bit b2b);
    logic [31:0] es;
    logic        est;
    int          idx;
    int          cyc;
    ref_sum(v, es, est);
    chk("idle_busy", busy_o, 0);
    chk("idle_ready", ready_o, 0);
    start_i = 1'b1;
    len_i   = 10'(v.size());
    @(negedge clk_i);
    start_i = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < v.size() && cyc < 300) begin
      start_i = 1'b0;
      chk("acc_ready", ready_o, 1);
      chk("acc_nvalid", sum_valid_o, 0);
      valid_i = !(cyc < 32 && gaps[cyc]);
      data_i  = v[idx];
      if (ign_start && cyc == 1) begin
        start_i = 1'b1;
        len_i   = 10'd5;
      end
      @(negedge clk_i);
      if (valid_i) idx++;
      cyc++;
    end
    if (cyc >= 300) chk("acc_timeout", 1, 0);
    valid_i = 1'b0;
    start_i = 1'b0;
    chk("done_valid", sum_valid_o, 1);
    chk("done_ready", ready_o, 0);
    chk("done_sum", sum_o, es);
    chk("done_sat", sat_o, est);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk_i);
      chk("stall_valid", sum_valid_o, 1);
      chk("stall_sum", sum_o, es);
    end
    sum_ready_i = 1'b1;
    if (b2b) begin
      start_i = 1'b1;
      len_i   = 10'd3;
    end
    @(negedge clk_i);
    sum_ready_i = 1'b0;
    start_i     = 1'b0;
    chk("post_valid", sum_valid_o, 0);
    chk("post_busy", busy_o, 0);
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 32'h0004_0000);
      1:       return $urandom;
      2:       return 32'h7F00_0000 | ($urandom & 32'h00FF_FFFF);
      default: return 32'h8000_0000 | ($urandom & 32'h00FF_FFFF);
    endcase
  endfunction

  initial begin
    logic [31:0] v[$];
    rst_i       = 1'b1;
    start_i     = 1'b0;
    len_i       = '0;
    data_i      = '0;
    valid_i     = 1'b0;
    sum_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", sum_valid_o, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_sum", sum_o, 0);

    // Abort a vector with reset after two elements.
    start_i = 1'b1;
    len_i   = 10'd4;
    @(negedge clk_i);
    start_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'h0003_0000;
    repeat (2) @(negedge clk_i);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort_valid", sum_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_sum", sum_o, 0);
    v = '{32'h0001_0000};
    run_vec(v, 0, 0, 0, 0);

    // Basic sum 1.0 + 0.5 + 0.25.
    v = '{32'h0001_0000, 32'h0000_8000, 32'h0000_4000};
    run_vec(v, 0, 0, 0, 0);
    // Gapped input (1,0,0,1) and consumer stall.
    v = '{32'h0001_0000, 32'h0000_C000};
    run_vec(v, 32'b0110, 5, 0, 0);
    // Positive clamp then recovery by -1.0.
    v = '{32'h7FFF_0000, 32'h0002_0000, 32'hFFFF_0000};
    run_vec(v, 0, 0, 0, 0);
    // Negative clamp.
    v = '{32'h8000_0000, 32'hFFFF_FFFF};
    run_vec(v, 0, 0, 0, 0);

    // Zero length: DONE straight away with sum 0.
    start_i = 1'b1;
    len_i   = 10'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("len0_valid", sum_valid_o, 1);
    chk("len0_sum", sum_o, 0);
    chk("len0_sat", sat_o, 0);
    chk("len0_ready", ready_o, 0);
    sum_ready_i = 1'b1;
    @(negedge clk_i);
    sum_ready_i = 1'b0;
    chk("len0_post", busy_o, 0);

    // Start pulse during ACC is ignored; start with DONE->IDLE too.
    v = '{32'h0002_0000, 32'h0000_1000};
    run_vec(v, 0, 0, 1, 1);

    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(1, 12);
      v = {};
      for (int i = 0; i < n; i++) v.push_back(rnd_data());
      run_vec(v, $urandom & $urandom, $urandom_range(0, 3),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    v = {};
    for (int i = 0; i < 40; i++) v.push_back(rnd_data());
    run_vec(v, $urandom & $urandom, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
